// File: rtl/cpu_microsequencer_if.sv
// Sequencer bus: microword sequencing fields and status in, control address
// and sequencer status out.
interface cpu_microsequencer_if #(
    parameter int CADDR_W = 10,
    parameter int OPC_W   = 8
);
    logic               hlt;
    logic [OPC_W-1:0]   opcode;
    logic [3:0]         flags;        // {sign, zero, parity, carry}
    logic [1:0]         next_sel;
    logic [2:0]         cond_sel;
    logic [CADDR_W-1:0] branch_addr;
    logic [CADDR_W-1:0] car;
    logic [3:0]         tstep;
    logic               halted;
    logic               ucode_err;

    // Driver side (CPU control unit / testbench)
    modport master (
        output hlt, opcode, flags, next_sel, cond_sel, branch_addr,
        input  car, tstep, halted, ucode_err
    );

    // Sequencer side
    modport slave (
        input  hlt, opcode, flags, next_sel, cond_sel, branch_addr,
        output car, tstep, halted, ucode_err
    );
endinterface

// File: rtl/cpu_microsequencer.sv
// Next-address controller for the microcode control ROM. Picks the next
// control address from increment / opcode map / conditional branch / fetch,
// counts micro-steps since the last fetch, and parks in HALT at a fetch
// boundary while hlt is held.
module cpu_microsequencer #(
    parameter int                 CADDR_W    = 10,
    parameter int                 OPC_W      = 8,
    parameter logic [CADDR_W-1:0] RESET_ADDR = 10'h000,
    parameter logic [CADDR_W-1:0] FETCH_ADDR = 10'h000,
    parameter logic [CADDR_W-1:0] MAP_OFFSET = 10'h004
) (
    input  logic                 clk,
    input  logic                 reset,     // asynchronous, active low
    cpu_microsequencer_if.slave  bus
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [1:0] SEL_INC    = 2'b00;
    localparam logic [1:0] SEL_MAP    = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_FETCH  = 2'b11;

    state_t             state, state_nx;
    logic [CADDR_W-1:0] car_q, car_nx;
    logic [3:0]         tstep_q, tstep_nx;
    logic               err_q, err_nx;

    logic               cond_true;
    logic [CADDR_W-1:0] inc_addr;
    logic               inc_wraps;
    logic [CADDR_W-1:0] map_addr;
    logic [3:0]         tstep_sat;

    wire sign_f   = bus.flags[3];
    wire zero_f   = bus.flags[2];
    wire parity_f = bus.flags[1];
    wire carry_f  = bus.flags[0];

    // Sequential increment and its wrap detect (wrap = microcode ran off the top).
    assign inc_addr  = car_q + CADDR_W'(1);
    assign inc_wraps = &car_q;

    // Opcode map target; overflow past the top of the ROM wraps silently.
    assign map_addr  = CADDR_W'(32'(MAP_OFFSET) + 32'(bus.opcode));

    // Micro-step counter saturates rather than wrapping.
    assign tstep_sat = (tstep_q == 4'hF) ? 4'hF : tstep_q + 4'd1;

    // Branch condition decode; every encoding is defined, 7 is never taken.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond_sel)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = carry_f;
            3'd2: cond_true = parity_f;
            3'd3: cond_true = zero_f;
            3'd4: cond_true = sign_f;
            3'd5: cond_true = ~zero_f;
            3'd6: cond_true = ~carry_f;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state / next-address selection.
    always_comb begin
        state_nx = state;
        car_nx   = car_q;
        tstep_nx = tstep_q;
        err_nx   = err_q;
        case (state)
            S_RUN: begin
                case (bus.next_sel)
                    SEL_INC: begin
                        car_nx   = inc_addr;
                        tstep_nx = tstep_sat;
                        if (inc_wraps) err_nx = 1'b1;
                    end
                    SEL_MAP: begin
                        car_nx   = map_addr;
                        tstep_nx = tstep_sat;
                    end
                    SEL_BRANCH: begin
                        tstep_nx = tstep_sat;
                        if (cond_true) begin
                            car_nx = bus.branch_addr;
                        end else begin
                            car_nx = inc_addr;
                            if (inc_wraps) err_nx = 1'b1;
                        end
                    end
                    default: begin  // SEL_FETCH: only place a halt is honoured
                        car_nx   = FETCH_ADDR;
                        tstep_nx = 4'd0;
                        if (bus.hlt) state_nx = S_HALT;
                    end
                endcase
            end
            default: begin  // S_HALT: park on the fetch address, ignore microword
                car_nx   = FETCH_ADDR;
                tstep_nx = 4'd0;
                if (!bus.hlt) state_nx = S_RUN;
            end
        endcase
    end

    // State and address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_RUN;
            car_q   <= RESET_ADDR;
            tstep_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            car_q   <= car_nx;
            tstep_q <= tstep_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.car       = car_q;
    assign bus.tstep     = tstep_q;
    assign bus.halted    = (state == S_HALT);
    assign bus.ucode_err = err_q;

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Directed bench for cpu_microsequencer: a behavioural model of the
// sequencing rules is checked against the DUT every negedge, and literal
// expectations at key points pin the model.
module tb_cpu_microsequencer;

    localparam logic [1:0] INC = 2'b00, MAP = 2'b01, BR = 2'b10, FET = 2'b11;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cpu_microsequencer_if #(.CADDR_W(10), .OPC_W(8)) bus ();

    cpu_microsequencer #(
        .CADDR_W(10), .OPC_W(8),
        .RESET_ADDR(10'h000), .FETCH_ADDR(10'h000), .MAP_OFFSET(10'h004)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_car, m_tstep;
    bit m_halt, m_err;

    function automatic bit cond_ok(input int c, input logic [3:0] f);
        // f = {sign, zero, parity, carry}
        case (c)
            0: return 1;
            1: return f[0];
            2: return f[1];
            3: return f[2];
            4: return f[3];
            5: return !f[2];
            6: return !f[0];
            default: return 0;
        endcase
    endfunction

    function automatic void m_advance();
        if (m_car == 1023) m_err = 1;
        m_car = (m_car + 1) % 1024;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_car = 0; m_tstep = 0; m_halt = 0; m_err = 0;
        end else if (m_halt) begin
            m_car = 0; m_tstep = 0;
            if (!bus.hlt) m_halt = 0;
        end else begin
            case (bus.next_sel)
                FET: begin
                    m_car = 0; m_tstep = 0;
                    if (bus.hlt) m_halt = 1;
                end
                MAP: m_car = (4 + int'(bus.opcode)) % 1024;
                BR:  if (cond_ok(int'(bus.cond_sel), bus.flags)) m_car = int'(bus.branch_addr);
                     else m_advance();
                default: m_advance();
            endcase
            if (bus.next_sel != FET && m_tstep < 15) m_tstep++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("car",       int'(bus.car),       m_car);
        chk("tstep",     int'(bus.tstep),     m_tstep);
        chk("halted",    int'(bus.halted),    int'(m_halt));
        chk("ucode_err", int'(bus.ucode_err), int'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] ns, input logic [2:0] cs,
                        input logic [9:0] ba, input logic [7:0] op,
                        input logic [3:0] fl);
        bus.next_sel    = ns;
        bus.cond_sel    = cs;
        bus.branch_addr = ba;
        bus.opcode      = op;
        bus.flags       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_car",    int'(bus.car),       0);
        chk("rst_tstep",  int'(bus.tstep),     0);
        chk("rst_halted", int'(bus.halted),    0);
        chk("rst_err",    int'(bus.ucode_err), 0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.hlt = 1'b0; bus.opcode = '0; bus.flags = '0;
        bus.next_sel = INC; bus.cond_sel = '0; bus.branch_addr = '0;
        #2;
        chk("por_car",   int'(bus.car),   0);
        chk("por_tstep", int'(bus.tstep), 0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Reset mid-count from car=0x023
        step(INC, 0, 0, 0, 0);
        step(BR, 0, 10'h023, 0, 0);
        chk("pre_rst_car", int'(bus.car), 'h023);
        pulse_reset();
        for (int i = 1; i <= 3; i++) begin
            step(INC, 0, 0, 0, 0);
            chk("inc_car",   int'(bus.car),   i);
            chk("inc_tstep", int'(bus.tstep), i);
        end

        // Opcode map
        step(MAP, 0, 0, 8'h12, 0);
        chk("map_12", int'(bus.car), 'h016);
        step(MAP, 0, 0, 8'hFF, 0);
        chk("map_ff", int'(bus.car), 'h103);

        // Conditional branch from 0x050 with zero set
        step(BR, 0, 10'h050, 0, 0);
        step(BR, 3, 10'h200, 0, 4'b0100);
        chk("br_zero_taken", int'(bus.car), 'h200);
        step(BR, 0, 10'h050, 0, 0);
        step(BR, 5, 10'h200, 0, 4'b0100);
        chk("br_nzero_untaken", int'(bus.car), 'h051);
        step(BR, 0, 10'h050, 0, 0);
        step(BR, 7, 10'h200, 0, 4'b1111);
        chk("br_never", int'(bus.car), 'h051);
        step(BR, 1, 10'h123, 0, 4'b0001);
        chk("br_carry", int'(bus.car), 'h123);

        // hlt pulse that drops before a fetch is ignored
        step(FET, 0, 0, 0, 0);
        bus.hlt = 1'b1;
        step(INC, 0, 0, 0, 0);
        bus.hlt = 1'b0;
        step(FET, 0, 0, 0, 0);
        chk("hlt_pulse_ignored", int'(bus.halted), 0);

        // Halt honoured only at fetch
        bus.hlt = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(INC, 0, 0, 0, 0);
            chk("hlt_inc_car", int'(bus.car), i);
            chk("hlt_inc_halted", int'(bus.halted), 0);
        end
        step(FET, 0, 0, 0, 0);
        chk("halt_car", int'(bus.car), 0);
        chk("halt_flag", int'(bus.halted), 1);
        for (int i = 0; i < 10; i++) begin
            step(2'(i), 3'(i), 10'h3AA, 8'h55, 4'hF);
            chk("halt_hold_car",    int'(bus.car),    0);
            chk("halt_hold_tstep",  int'(bus.tstep),  0);
            chk("halt_hold_halted", int'(bus.halted), 1);
        end
        bus.hlt = 1'b0;
        step(INC, 0, 0, 0, 0);
        chk("resume_halted", int'(bus.halted), 0);
        chk("resume_car",    int'(bus.car),    0);
        step(INC, 0, 0, 0, 0);
        chk("resume_inc", int'(bus.car), 1);

        // Wrap on INC sets sticky ucode_err
        step(BR, 0, 10'h3FF, 0, 0);
        step(INC, 0, 0, 0, 0);
        chk("wrap_car", int'(bus.car), 0);
        chk("wrap_err", int'(bus.ucode_err), 1);
        step(FET, 0, 0, 0, 0);
        step(INC, 0, 0, 0, 0);
        chk("err_sticky", int'(bus.ucode_err), 1);
        pulse_reset();

        // Wrap on untaken branch
        step(BR, 0, 10'h3FF, 0, 0);
        step(BR, 7, 10'h100, 0, 0);
        chk("br_wrap_car", int'(bus.car), 0);
        chk("br_wrap_err", int'(bus.ucode_err), 1);
        pulse_reset();

        // tstep saturation
        step(FET, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(INC, 0, 0, 0, 0);
            if (i == 15 || i == 20) chk("tstep_sat", int'(bus.tstep), 15);
        end
        chk("sat_car", int'(bus.car), 20);
        step(FET, 0, 0, 0, 0);
        chk("fetch_tstep", int'(bus.tstep), 0);

        step(INC, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_microsequencer.md
Name: cpu_microsequencer

Overview:
- Next-address controller for the CPU's 1024x64 microcode control ROM. Replaces the free-running CAR counter and the fixed CAR input mux.
- Every cycle it selects the next control address from one of four sources: increment, opcode map, conditional branch, or return to fetch. It also tracks the micro-step count and implements the hlt stop/resume protocol.
- In the CPU it is clocked from clk_n, so the control ROM output settles before the datapath edge.

Parameters:
- CADDR_W, 10, control address width (indexes the 1024-entry ROM)
- OPC_W, 8, opcode width (IR1)
- RESET_ADDR, 10'h000, control address loaded at reset
- FETCH_ADDR, 10'h000, first microinstruction of the fetch routine
- MAP_OFFSET, 10'h004, control ROM base of the opcode microroutines

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (clears all state while 0)
- hlt  input  1  halt request, level sensitive
- opcode  input  OPC_W  IR1 contents (instruction opcode)
- flags  input  4  {sign, zero, parity, carry} from the status register
- next_sel  input  2  sequencing field of the current microword: 00 INC, 01 MAP, 10 BRANCH, 11 FETCH
- cond_sel  input  3  branch condition: 0 always, 1 carry, 2 parity, 3 zero, 4 sign, 5 !zero, 6 !carry, 7 never
- branch_addr  input  CADDR_W  branch target from the microword
- car  output  CADDR_W  control address to the control ROM
- tstep  output  4  micro-step count since the last fetch (T state)
- halted  output  1  sequencer parked in HALT
- ucode_err  output  1  sticky; set when an increment wraps past the top address

Behaviour:
- Reset (reset=0, asynchronous): car=RESET_ADDR, tstep=0, halted=0, ucode_err=0, state=RUN.
- Two states, RUN and HALT. All inputs are sampled at the rising edge; car updates at that same edge, so car lags its source by one cycle.
- RUN, next-address select:
  - INC: car <= car+1, tstep <= tstep+1.
  - MAP: car <= (MAP_OFFSET + zero-extended opcode) truncated to CADDR_W (modulo 1024), tstep <= tstep+1.
  - BRANCH: cond true -> car <= branch_addr, else car <= car+1; tstep <= tstep+1. Condition is evaluated on the flags value at the same edge.
  - FETCH, hlt=0: car <= FETCH_ADDR, tstep <= 0.
  - FETCH, hlt=1: car <= FETCH_ADDR, tstep <= 0, state <= HALT, halted <= 1.
- Halt timing:
  - hlt is honoured only at a FETCH boundary; an instruction in progress always completes.
  - hlt rising then falling again before any FETCH has no effect.
- HALT:
  - car holds FETCH_ADDR and tstep holds 0; next_sel, cond_sel, opcode and flags are ignored.
  - When hlt=0 at an edge: state <= RUN, halted <= 0, car stays FETCH_ADDR. The fetch microinstruction executes in the following cycle.
- tstep saturates at 4'hF; it does not wrap.
- Wrap boundaries:
  - INC, or an untaken BRANCH, at car=10'h3FF wraps to 10'h000 and sets ucode_err.
  - ucode_err is cleared only by reset.
  - MAP overflow wraps silently and does not set ucode_err.
- Reset asserted mid-routine or in HALT forces the reset values immediately, with no clock required. On deassertion, the first edge acts on the microword at RESET_ADDR.
- next_sel and cond_sel have no X-propagation special case: all encodings are defined and cond_sel=7 is a never-taken branch.

Test Plan:
- Reset: reset=0 mid-count with car=10'h023 -> car=10'h000, tstep=0, halted=0, ucode_err=0 before the next edge. Release, drive INC x3 -> car 1,2,3 and tstep 1,2,3.
- Map: opcode=8'h12, next_sel=MAP -> car=10'h016. Opcode=8'hFF, next_sel=MAP -> car=10'h103.
- Branch: flags=4'b0100 (zero set), cond_sel=3, branch_addr=10'h200 from car=10'h050 -> car=10'h200. Same with cond_sel=5 -> car=10'h051. cond_sel=7 -> car=10'h051.
- Halt: hlt=1 asserted during INC steps -> car keeps incrementing until FETCH, then car=10'h000 and halted=1, held for 10 cycles. hlt=0 -> halted=0 next edge, car stays 10'h000, and the next INC gives 10'h001.
- Wrap: car=10'h3FF with INC -> car=10'h000 and ucode_err=1. ucode_err remains 1 after further FETCH/INC until reset.
- Tstep saturation: 20 consecutive INC -> tstep stops at 4'hF; a following FETCH -> tstep=0.
